// File: rtl/traffic_light_ctrl_if.sv
// Lamp/request bundle between the tick-driven light sequencer and its surroundings.
// Handshake: no valid/ready pair here; tick is a one-clk enable strobe and every other signal is level-sampled on each clk.
interface traffic_light_ctrl_if #(
    parameter int TW = 8
);
    logic          tick;
    logic          ped_req;
    logic          night_mode;
    logic [2:0]    main_rgy;
    logic [2:0]    side_rgy;
    logic          walk;
    logic [2:0]    phase;
    logic [TW-1:0] timer;

    modport master (
        output tick, ped_req, night_mode,
        input  main_rgy, side_rgy, walk, phase, timer
    );

    modport slave (
        input  tick, ped_req, night_mode,
        output main_rgy, side_rgy, walk, phase, timer
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with pedestrian walk request and night flash mode.
// All phase durations are counted in ticks of the upstream divider strobe.
module traffic_light_ctrl #(
    parameter int T_MAIN_GREEN = 20,
    parameter int T_MAIN_MIN   = 6,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_SIDE_GREEN = 10,
    parameter int TW           = 8
) (
    input logic                  clk,
    input logic                  reset,
    traffic_light_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        FLASH       = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [TW-1:0] LD_MAIN_GREEN = TW'(T_MAIN_GREEN - 1);
    localparam logic [TW-1:0] LD_YELLOW     = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] LD_ALL_RED    = TW'(T_ALL_RED - 1);
    localparam logic [TW-1:0] LD_SIDE_GREEN = TW'(T_SIDE_GREEN - 1);
    // Timer value at the T_MAIN_MIN-th tick of main green; at or below it a pending request may cut green short.
    localparam logic [TW-1:0] EARLY_LIMIT   = TW'(T_MAIN_GREEN - T_MAIN_MIN);

    state_t        state, next_state;
    logic [TW-1:0] timer, next_timer;
    logic          ped_pending, next_ped_pending;
    logic          walk_grant, next_walk_grant;
    logic          flash_phase, next_flash_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ALL_RED_2;
            timer       <= '0;
            ped_pending <= 1'b0;
            walk_grant  <= 1'b0;
            flash_phase <= 1'b0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            ped_pending <= next_ped_pending;
            walk_grant  <= next_walk_grant;
            flash_phase <= next_flash_phase;
        end
    end

    always_comb begin
        next_state       = state;
        next_timer       = timer;
        next_ped_pending = ped_pending | bus.ped_req;
        next_walk_grant  = walk_grant;
        next_flash_phase = flash_phase;

        case (state)
            MAIN_GREEN: if (bus.tick) begin
                if (timer == '0 || (ped_pending && timer <= EARLY_LIMIT)) begin
                    next_state = MAIN_YELLOW;
                    next_timer = LD_YELLOW;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            MAIN_YELLOW: if (bus.tick) begin
                if (timer == '0) begin
                    next_state = ALL_RED_1;
                    next_timer = LD_ALL_RED;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            ALL_RED_1: if (bus.tick) begin
                if (timer == '0) begin
                    next_state = bus.night_mode ? FLASH : SIDE_GREEN;
                    next_timer = bus.night_mode ? '0 : LD_SIDE_GREEN;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            SIDE_GREEN: if (bus.tick) begin
                if (timer == '0) begin
                    next_state = SIDE_YELLOW;
                    next_timer = LD_YELLOW;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            SIDE_YELLOW: if (bus.tick) begin
                if (timer == '0) begin
                    next_state = ALL_RED_2;
                    next_timer = LD_ALL_RED;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            ALL_RED_2: if (bus.tick) begin
                if (timer == '0) begin
                    next_state = bus.night_mode ? FLASH : MAIN_GREEN;
                    next_timer = bus.night_mode ? '0 : LD_MAIN_GREEN;
                end else begin
                    next_timer = timer - 1'b1;
                end
            end
            FLASH: if (bus.tick) begin
                if (!bus.night_mode) begin
                    next_state = ALL_RED_2;
                    next_timer = LD_ALL_RED;
                end else begin
                    next_timer = '0;
                end
            end
            default: begin
                next_state = ALL_RED_2;
                next_timer = LD_ALL_RED;
            end
        endcase

        // A request on the entry clk is folded into the grant rather than left pending.
        if (state != SIDE_GREEN && next_state == SIDE_GREEN) begin
            next_walk_grant  = ped_pending | bus.ped_req;
            next_ped_pending = 1'b0;
        end else if (state == SIDE_GREEN && next_state != SIDE_GREEN) begin
            next_walk_grant  = 1'b0;
        end

        if (state != FLASH && next_state == FLASH) begin
            next_flash_phase = 1'b1;
        end else if (state == FLASH && bus.tick) begin
            next_flash_phase = ~flash_phase;
        end
    end

    always_comb begin
        bus.main_rgy = LAMP_RED;
        bus.side_rgy = LAMP_RED;
        bus.walk     = 1'b0;
        bus.phase    = state;
        bus.timer    = timer;
        case (state)
            MAIN_GREEN:  bus.main_rgy = LAMP_GRN;
            MAIN_YELLOW: bus.main_rgy = LAMP_YEL;
            SIDE_GREEN: begin
                bus.side_rgy = LAMP_GRN;
                bus.walk     = walk_grant;
            end
            SIDE_YELLOW: bus.side_rgy = LAMP_YEL;
            FLASH: begin
                bus.main_rgy = {1'b0, flash_phase, 1'b0};
                bus.side_rgy = {1'b0, flash_phase, 1'b0};
            end
            default: begin
                bus.main_rgy = LAMP_RED;
                bus.side_rgy = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: table of phase records plus hand-written
// sequences for reset, flash mode and the pedestrian corner cases.
module tb_traffic_light_ctrl;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [2:0] P_MG  = 3'd0;
    localparam logic [2:0] P_MY  = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_SG  = 3'd3;
    localparam logic [2:0] P_SY  = 3'd4;
    localparam logic [2:0] P_AR2 = 3'd5;
    localparam logic [2:0] P_FL  = 3'd6;

    typedef struct {
        logic [2:0] phase;
        int         tmr0;
        int         len;
        logic [2:0] main_exp;
        logic [2:0] side_exp;
        logic       walk_exp;
        int         ped_k;
        int         night_from;
        int         gap;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t tbl[$];

    traffic_light_ctrl_if #(.TW(8)) bus ();

    traffic_light_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] ph, input int tmr0, input int len,
                                input logic [2:0] m, input logic [2:0] s, input logic w,
                                input int ped_k, input int night_from, input int gap);
        vec_t v;
        v.phase = ph; v.tmr0 = tmr0; v.len = len;
        v.main_exp = m; v.side_exp = s; v.walk_exp = w;
        v.ped_k = ped_k; v.night_from = night_from; v.gap = gap;
        return v;
    endfunction

    task automatic step(input logic t, input logic p, input logic n);
        bus.tick       = t;
        bus.ped_req    = p;
        bus.night_mode = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [2:0] ph, input logic [7:0] tm,
                         input logic [2:0] m, input logic [2:0] s, input logic w);
        tests++;
        if ({bus.phase, bus.timer, bus.main_rgy, bus.side_rgy, bus.walk} !== {ph, tm, m, s, w}) begin
            fails++;
            $display("FAIL %s: got phase=%0d timer=%0d main=%b side=%b walk=%b, want phase=%0d timer=%0d main=%b side=%b walk=%b",
                     name, bus.phase, bus.timer, bus.main_rgy, bus.side_rgy, bus.walk, ph, tm, m, s, w);
        end
    endtask

    task automatic run_table(input string label);
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].len; k++) begin
                logic       nt;
                logic [7:0] et;
                nt = (tbl[i].night_from >= 0) && (k >= tbl[i].night_from);
                et = 8'(tbl[i].tmr0 - k);
                check($sformatf("%s row%0d ph%0d k%0d", label, i, tbl[i].phase, k),
                      tbl[i].phase, et, tbl[i].main_exp, tbl[i].side_exp, tbl[i].walk_exp);
                for (int g = 0; g < tbl[i].gap; g++) begin
                    step(1'b0, 1'b0, nt);
                    check($sformatf("%s row%0d hold k%0d g%0d", label, i, k, g),
                          tbl[i].phase, et, tbl[i].main_exp, tbl[i].side_exp, tbl[i].walk_exp);
                end
                step(1'b1, k == tbl[i].ped_k, nt);
            end
        end
        tbl.delete();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;
        bus.night_mode = 1'b0;
        @(negedge clk);

        // Reset state, with tick high to show reset wins
        step(1'b1, 1'b0, 1'b0);
        check("reset", P_AR2, 8'd0, RED, RED, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("idle hold", P_AR2, 8'd0, RED, RED, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Plain 38-tick cycle
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        run_table("t1");

        // Request on the 2nd green tick: green cut at tick 6, walk granted, next green full
        tbl.push_back(mk(P_MG, 19,  6, GRN, RED, 1'b0,  1, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b1, -1, -1, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        run_table("t2");

        // Request latched at tick 12: green exits on tick 13
        tbl.push_back(mk(P_MG, 19, 13, GRN, RED, 1'b0, 11, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b1, -1, -1, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        run_table("t3");

        // Night mode raised mid side green: sequence completes, then flash
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b0, -1,  5, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1,  0, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1,  0, 0));
        run_table("t4");
        check("flash entry", P_FL, 8'd0, YEL, YEL, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("flash hold", P_FL, 8'd0, YEL, YEL, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("flash t1", P_FL, 8'd0, OFF, OFF, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("flash t2", P_FL, 8'd0, YEL, YEL, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("flash t3", P_FL, 8'd0, OFF, OFF, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("flash exit", P_AR2, 8'd0, RED, RED, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Tick every 5th clk, request in main yellow, reset mid side green
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 4));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0,  0, -1, 4));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0, -1, -1, 4));
        tbl.push_back(mk(P_SG,  9,  4, RED, GRN, 1'b1, -1, -1, 4));
        run_table("t5");
        check("pre reset", P_SG, 8'd5, RED, GRN, 1'b1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("mid reset", P_AR2, 8'd0, RED, RED, 1'b0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);

        // Request on the AR1->SG entry clk: walk granted, not re-latched
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MY,  2,  3, YEL, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR1, 0,  1, RED, RED, 1'b0,  0, -1, 0));
        tbl.push_back(mk(P_SG,  9, 10, RED, GRN, 1'b1, -1, -1, 0));
        tbl.push_back(mk(P_SY,  2,  3, RED, YEL, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_AR2, 0,  1, RED, RED, 1'b0, -1, -1, 0));
        tbl.push_back(mk(P_MG, 19, 20, GRN, RED, 1'b0, -1, -1, 0));
        run_table("t6");
        check("t6 final", P_MY, 8'd2, YEL, RED, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Two-road traffic-light sequencer with a pedestrian walk request and a night flash mode.
- Sits directly downstream of the programmable tick divider. It consumes the divider's one-`clk`-wide "signal" strobe as `tick`.
- All phase durations are counted in ticks, so the external divide setting scales the whole light cycle.
- Outputs drive the lamp pins, plus a phase/timer debug view.

Parameters:
- T_MAIN_GREEN, 20, main-road green length in ticks (≥ T_MAIN_MIN)
- T_MAIN_MIN, 6, minimum main green before a pedestrian request may cut it short (≥1)
- T_YELLOW, 3, yellow length in ticks, both roads (≥1)
- T_ALL_RED, 1, all-red clearance length in ticks (≥1)
- T_SIDE_GREEN, 10, side-road green / walk length in ticks (≥1)
- TW, 8, phase timer width; every duration must be ≤ 2**TW

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  time-base enable strobe, synchronous to clk; each high cycle counts as one tick
- ped_req  in  1  pedestrian button, synchronous, any width
- night_mode  in  1  request flashing-yellow operation
- main_rgy  out  3  main road lamps {red, yellow, green}
- side_rgy  out  3  side road lamps {red, yellow, green}
- walk  out  1  pedestrian walk lamp
- phase  out  3  current state encoding (debug)
- timer  out  TW  remaining ticks in phase minus one (debug)

Behaviour:
- States and encodings:
  - MAIN_GREEN = 0
  - MAIN_YELLOW = 1
  - ALL_RED_1 = 2
  - SIDE_GREEN = 3
  - SIDE_YELLOW = 4
  - ALL_RED_2 = 5
  - FLASH = 6
  - Code 7 is illegal and recovers to ALL_RED_2 on the next clk.
- Reset (clk edge with reset=1; reset overrides tick):
  - state=ALL_RED_2, timer=0, ped_pending=0, walk_grant=0, flash_phase=0.
  - Outputs: main_rgy=100, side_rgy=100, walk=0.
- Timer and transitions:
  - On entry to a phase, timer loads that phase's duration − 1.
  - On each clk with tick=1 and timer≠0, timer decrements.
  - On a clk with tick=1 and timer=0, the phase exits.
  - A phase of duration N therefore lasts exactly N ticks.
  - With tick=0, state and timer hold.
- Sequence: MAIN_GREEN → MAIN_YELLOW → ALL_RED_1 → SIDE_GREEN → SIDE_YELLOW → ALL_RED_2 → MAIN_GREEN.
- Early exit from MAIN_GREEN:
  - Condition: tick=1, ped_pending=1 and timer ≤ T_MAIN_GREEN − T_MAIN_MIN.
  - Result: exit to MAIN_YELLOW. The earliest exit is at the T_MAIN_MIN-th tick of green.
- Outputs are Moore-decoded from the state register and change on the clk after the exiting tick:
  - MAIN_GREEN: main 001, side 100
  - MAIN_YELLOW: main 010, side 100
  - SIDE_GREEN: main 100, side 001
  - SIDE_YELLOW: main 100, side 010
  - ALL_RED_x: both 100
  - FLASH: both {0, flash_phase, 0}
- Pedestrian request:
  - ped_pending sets on any clk with ped_req=1.
  - On entry to SIDE_GREEN: walk_grant ← ped_pending | ped_req, and ped_pending clears.
  - If ped_req is high on that same entry clk, it is counted in the grant and not re-latched.
  - walk = (state==SIDE_GREEN) & walk_grant. walk_grant clears on SIDE_GREEN exit.
  - A request arriving during SIDE_GREEN stays pending for the next cycle of the sequence.
- Night mode:
  - night_mode is evaluated only at the exiting tick of ALL_RED_1 or ALL_RED_2.
  - If night_mode=1 at that tick, next state is FLASH. Green or yellow phases are never abandoned mid-phase.
  - FLASH: flash_phase starts at 1 and toggles on every tick; timer is held at 0; walk=0; ped_pending keeps latching.
  - Exit: a tick with night_mode=0 while in FLASH → ALL_RED_2 with a full T_ALL_RED, then MAIN_GREEN.
- Safety invariants:
  - Never green or yellow on both roads at once, except yellow/yellow in FLASH.
  - walk=1 only while side_rgy=001.
- tick held high continuously: one tick per clk. The divider's minimum tick spacing is 1 cycle.

Test Plan:
1. Reset, then tick every clk, ped_req=0, night_mode=0.
   - First tick → MAIN_GREEN.
   - Phase lengths must be exactly 20/3/1/10/3/1 ticks, a 38-tick period, with lamp codes per state.
2. ped_req pulsed 1 clk during the 2nd tick of MAIN_GREEN.
   - MAIN_GREEN exits at tick 6.
   - SIDE_GREEN shows walk=1 for all 10 ticks; ped_pending=0 afterwards.
   - The next cycle has a full 20-tick green.
3. ped_req pulsed after tick 12 of MAIN_GREEN → green exits on the next tick (tick 13).
4. night_mode raised mid-SIDE_GREEN.
   - Sequence completes SIDE_YELLOW and ALL_RED_2, then enters FLASH with both yellows alternating 1,0,1,… per tick.
   - Dropping night_mode → ALL_RED_2 for 1 tick, then MAIN_GREEN.
5. tick asserted every 5th clk.
   - State and timer hold between ticks; phase lengths are still counted in ticks.
   - reset asserted mid-SIDE_GREEN with walk=1 → next clk: both 100, walk=0, phase=5, timer=0.
6. ped_req asserted exactly on the ALL_RED_1 → SIDE_GREEN transition clk.
   - walk=1 throughout that SIDE_GREEN.
   - ped_pending=0 after entry; no early exit in the following MAIN_GREEN.
